// File: rtl/green_commit_stage.sv
// Commit stage behind the green block: optional data-memory store, then PC commit with redirect/retire pulses.
// Optional store timeout enabled by defining GREEN_MEM_TIMEOUT_EN.
module green_commit_stage #(
    parameter int            DW       = 16,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] ra_in,
    input  logic [DW-1:0] rb_in,
    input  logic          we_in,
    input  logic          br_in,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic          redirect,
    output logic          retire,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        COMMIT
    } state_t;

    state_t        state, state_nxt;
    logic          accept;
    logic          tmo_hit;
    logic          mem_exit;
    logic [AW-1:0] tgt_l;
    logic          br_l;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_exit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = we_in ? MEM : COMMIT;
                end
            end
            MEM: begin
                // an ack on the timeout cycle still counts as a completed store
                if (mem_ack || tmo_hit) begin
                    mem_exit  = 1'b1;
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            redirect  <= 1'b0;
            retire    <= 1'b0;
            tgt_l     <= '0;
            br_l      <= 1'b0;
        end else begin
            retire   <= 1'b0;
            redirect <= 1'b0;
            if (accept) begin
                tgt_l <= ra_in[AW-1:0];
                br_l  <= br_in;
                if (we_in) begin
                    mem_req   <= 1'b1;
                    mem_addr  <= ra_in[AW-1:0];
                    mem_wdata <= rb_in;
                end
            end
            if (mem_exit) begin
                mem_req <= 1'b0;
            end
            if (state == COMMIT) begin
                pc       <= br_l ? tgt_l : pc + AW'(1);
                retire   <= 1'b1;
                redirect <= br_l;
            end
        end
    end

`ifdef GREEN_MEM_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit = (state == MEM) && !mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt <= '0;
            end else if (state == MEM && !mem_ack) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_green_commit_stage.sv
// Scoreboard bench for green_commit_stage: driver pushes expected commits/stores, monitors pop and compare.
module tb_green_commit_stage;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] ra_in = '0;
    logic [DW-1:0] rb_in = '0;
    logic          we_in = 1'b0;
    logic          br_in = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] pc;
    logic          redirect;
    logic          retire;
    logic          err;

    green_commit_stage #(
        .DW(DW),
        .AW(AW),
        .RESET_PC(16'h0000),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ra_in(ra_in),
        .rb_in(rb_in),
        .we_in(we_in),
        .br_in(br_in),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .pc(pc),
        .redirect(redirect),
        .retire(retire),
        .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic          redir;
    } ret_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } st_t;

    ret_t          ret_q[$];
    st_t           st_q[$];
    logic [AW-1:0] model_pc = 16'h0000;

    int unsigned ack_target = 0;
    bit          no_ack = 1'b0;
    bit          noise = 1'b1;
    int unsigned last_req_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // memory responder: acks after ack_target+1 request cycles, random acks outside requests
    initial begin
        int unsigned ack_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (no_ack) begin
                    mem_ack = 1'b0;
                end else begin
                    mem_ack = (ack_cnt >= ack_target);
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
                mem_ack = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    // commit monitor
    initial begin
        logic [AW-1:0] committed = 16'h0000;
        bit            prev_retire = 1'b0;
        ret_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                committed   = 16'h0000;
                prev_retire = 1'b0;
            end else begin
                if (retire) begin
                    if (ret_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL retire_unexpected: got retire with empty queue, pc=%0h", pc);
                    end else begin
                        e = ret_q.pop_front();
                        check("retire_pc", 32'(pc), 32'(e.pc));
                        check("retire_redirect", 32'(redirect), 32'(e.redir));
                        committed = e.pc;
                    end
                    check("ready_on_retire", 32'(in_ready), 32'd1);
                    if (prev_retire) check("retire_width", 32'd1, 32'd0);
                end else begin
                    check("redirect_idle", 32'(redirect), 32'd0);
                    check("pc_hold", 32'(pc), 32'(committed));
                end
                prev_retire = retire;
            end
        end
    end

    // store monitor
    initial begin
        bit          prev_req = 1'b0;
        int unsigned req_len = 0;
        st_t         hold;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                req_len  = 0;
            end else begin
                if (mem_req) begin
                    if (!prev_req) begin
                        if (st_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL store_unexpected: got mem_req addr=%0h with empty queue", mem_addr);
                        end else begin
                            hold = st_q.pop_front();
                            check("store_addr", 32'(mem_addr), 32'(hold.addr));
                            check("store_data", 32'(mem_wdata), 32'(hold.data));
                        end
                        req_len = 1;
                    end else begin
                        check("addr_stable", 32'(mem_addr), 32'(hold.addr));
                        check("data_stable", 32'(mem_wdata), 32'(hold.data));
                        req_len++;
                    end
                    check("ready_low_in_mem", 32'(in_ready), 32'd0);
                end else if (prev_req) begin
                    last_req_len = req_len;
                end
                prev_req = mem_req;
            end
        end
    end

    task automatic send(input logic we, input logic br, input logic [DW-1:0] ra,
                        input logic [DW-1:0] rb, output int unsigned dcyc);
        int unsigned n = 0;
        ret_t r;
        st_t  s;
        while (!in_ready && n < 200) begin
            in_valid = 1'($urandom);
            ra_in    = DW'($urandom);
            rb_in    = DW'($urandom);
            we_in    = 1'($urandom);
            br_in    = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        in_valid = 1'b1;
        we_in    = we;
        br_in    = br;
        ra_in    = ra;
        rb_in    = rb;
        dcyc     = cyc;
        model_pc = br ? ra[AW-1:0] : model_pc + 16'h0001;
        r.pc     = model_pc;
        r.redir  = br;
        ret_q.push_back(r);
        if (we) begin
            s.addr = ra[AW-1:0];
            s.data = rb;
            st_q.push_back(s);
        end
        @(negedge clk);
        in_valid = 1'b0;
        ra_in    = DW'($urandom);
        rb_in    = DW'($urandom);
        we_in    = 1'($urandom);
        br_in    = 1'($urandom);
    endtask

    task automatic wait_retire(input string name, output int unsigned rcyc);
        int unsigned n = 0;
        while (!retire && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!retire) begin
            checks++;
            errors++;
            $display("FAIL %s: retire not seen within %0d cycles", name, n);
        end
        rcyc = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int unsigned d, r;
        int unsigned n;

        #12;
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pulses", {29'd0, retire, redirect, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // non-store, no branch from 0x0010
        send(1'b0, 1'b1, 16'h0010, 16'h0, d);
        wait_retire("t2_setup", r);
        send(1'b0, 1'b0, 16'hAAAA, 16'h5555, d);
        wait_retire("t2", r);
        check("t2_latency", r - d, 32'd2);
        check("t2_pc", 32'(pc), 32'h0011);
        check("t2_redirect", 32'(redirect), 32'd0);

        // branch
        send(1'b0, 1'b1, 16'h1234, 16'h0, d);
        wait_retire("t3", r);
        check("t3_latency", r - d, 32'd2);
        check("t3_pc", 32'(pc), 32'h1234);
        check("t3_redirect", 32'(redirect), 32'd1);
        @(negedge clk);
        check("t3_pulse_end", {30'd0, retire, redirect}, 32'd0);

        // store with 3-cycle request
        ack_target = 2;
        send(1'b1, 1'b0, 16'h0040, 16'hBEEF, d);
        wait_retire("t4", r);
        check("t4_req_len", last_req_len, 32'd3);
        check("t4_latency", r - d, 32'd5);
        check("t4_pc", 32'(pc), 32'h1235);

        // wrap, then store+branch to the same address
        send(1'b0, 1'b1, 16'hFFFF, 16'h0, d);
        wait_retire("t5_setup", r);
        send(1'b0, 1'b0, 16'h0, 16'h0, d);
        wait_retire("t5_wrap", r);
        check("t5_wrap_pc", 32'(pc), 32'h0000);
        ack_target = 0;
        send(1'b1, 1'b1, 16'h0200, 16'h5A5A, d);
        wait_retire("t5_webr", r);
        check("t5_webr_pc", 32'(pc), 32'h0200);
        check("t5_webr_redirect", 32'(redirect), 32'd1);
        check("t5_webr_req_len", last_req_len, 32'd1);
        check("t5_webr_latency", r - d, 32'd3);

        // randomized stream, back-to-back where possible
        for (int i = 0; i < 80; i++) begin
            ack_target = $urandom_range(0, 3);
            send(1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        n = 0;
        while ((ret_q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rand_drain", ret_q.size() + st_q.size(), 32'd0);
        check("rand_err", 32'(err), 32'd0);

        // memory never acks
        noise  = 1'b0;
        no_ack = 1'b1;
        send(1'b1, 1'b0, 16'h0300, 16'h1111, d);
`ifdef GREEN_MEM_TIMEOUT_EN
        wait_retire("t6_timeout", r);
        check("t6_req_len", last_req_len, 32'd4);
        check("t6_err", 32'(err), 32'd1);
        check("t6_pc", 32'(pc), 32'(model_pc));
        no_ack = 1'b0;
        noise  = 1'b1;
        send(1'b0, 1'b0, 16'h0, 16'h0, d);
        wait_retire("t6_after", r);
        check("t6_err_sticky", 32'(err), 32'd1);
`else
        repeat (100) @(negedge clk);
        check("t6_req_held", 32'(mem_req), 32'd1);
        check("t6_ready_low", 32'(in_ready), 32'd0);
        check("t6_no_err", 32'(err), 32'd0);
        no_ack = 1'b0;
        noise  = 1'b1;
        wait_retire("t6_release", r);
        check("t6_pc", 32'(pc), 32'(model_pc));
`endif

        // asynchronous reset in the middle of a pending store
        no_ack = 1'b1;
        send(1'b1, 1'b0, 16'h0400, 16'h2222, d);
        check("t1_req_before", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_pc", 32'(pc), 32'h0000);
        check("t1_ready", 32'(in_ready), 32'd1);
        check("t1_mem_req", 32'(mem_req), 32'd0);
        check("t1_mem_addr", 32'(mem_addr), 32'h0000);
        check("t1_pulses", {29'd0, retire, redirect, err}, 32'd0);
        ret_q.delete();
        st_q.delete();
        model_pc = 16'h0000;
        no_ack   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 1'b0, 16'h0, 16'h0, d);
        wait_retire("t1_after", r);
        check("t1_after_pc", 32'(pc), 32'h0001);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
